// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// 8N1 UART transmitter with a small byte FIFO in front of it.
// Bytes arrive over a req/ready handshake. They are buffered in a circular
// FIFO and serialised LSB-first on o_uart_tx at BAUD_DIVIDE clocks per bit.
// Back-to-back frames follow each other with no idle gap.
//
// Ports
//   i_clk            core clock, rising edge
//   i_reset          synchronous reset, active-high
//   i_tx_req         a byte is offered on i_tx_data
//   o_tx_ready       FIFO can accept a byte (transfer = i_tx_req && o_tx_ready)
//   i_tx_data        byte to send, sampled on a transfer cycle
//   o_tx_busy        a frame is on the line or the FIFO holds bytes
//   o_tx_fifo_level  bytes buffered, not counting the byte being shifted
//   o_uart_tx        serial line, idles high, straight from a flop
module uart_tx_fifo #(
    parameter int MAIN_CLK   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_tx_req,
    output logic                          o_tx_ready,
    input  logic [7:0]                    i_tx_data,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_tx_fifo_level,
    output logic                          o_uart_tx
);

    localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
    localparam int BW          = (BAUD_DIVIDE > 1) ? $clog2(BAUD_DIVIDE) : 1;
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int LW          = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIVIDE - 1);
    localparam logic [BW-1:0] BAUD_ZERO  = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ZERO   = PW'(0);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    // Index of the last stop bit; STOP_BITS is 1 or 2 so one bit is enough.
    localparam logic [0:0]    STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_reset_q;
    logic [7:0]      r_shift;
    logic [BW-1:0]   r_baud_cntr;
    logic [2:0]      r_bit_cntr;
    logic [0:0]      r_stop_cntr;
    logic            r_uart_tx;

    logic            w_push;
    logic            w_load;
    logic            w_pop;
    logic [7:0]      w_pop_data;

    // Ready comes only from registers so there is no path from i_tx_req.
    assign o_tx_ready      = !r_reset_q && (r_level != LEVEL_FULL);
    assign o_tx_busy       = (r_state != S_IDLE) || (r_level != LEVEL_ZERO);
    assign o_tx_fifo_level = r_level;
    assign o_uart_tx       = r_uart_tx;

    assign w_push     = i_tx_req && o_tx_ready;
    // The shifter takes a new byte when idle, or on the very last stop-bit
    // cycle so the next start bit follows with no gap.
    assign w_load     = (r_state == S_IDLE) ||
                        ((r_state == S_STOP) && (r_baud_cntr == BAUD_ZERO) &&
                         (r_stop_cntr == STOP_LAST));
    assign w_pop      = w_load && (r_level != LEVEL_ZERO);
    assign w_pop_data = r_mem[r_rd_ptr];

    // FIFO storage; flushing is done through the pointers, so no reset here.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tx_data;
        end
    end

    // FIFO pointers, occupancy and the delayed reset that gates ready.
    always_ff @(posedge i_clk) begin
        r_reset_q <= i_reset;
        if (i_reset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= LEVEL_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame sequencer: the line value for the next bit is registered on the
    // same edge as the state change so every bit lasts exactly BAUD_DIVIDE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_baud_cntr <= BAUD_ZERO;
            r_bit_cntr  <= 3'd0;
            r_stop_cntr <= 1'b0;
            r_uart_tx   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift     <= w_pop_data;
                        r_baud_cntr <= BAUD_LAST;
                        r_uart_tx   <= 1'b0;
                        r_state     <= S_START;
                    end else begin
                        r_uart_tx   <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_baud_cntr == BAUD_ZERO) begin
                        r_state     <= S_DATA;
                        r_bit_cntr  <= 3'd0;
                        r_baud_cntr <= BAUD_LAST;
                        r_uart_tx   <= r_shift[0];
                    end else begin
                        r_baud_cntr <= r_baud_cntr - BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud_cntr == BAUD_ZERO) begin
                        r_baud_cntr <= BAUD_LAST;
                        r_shift     <= {1'b0, r_shift[7:1]};
                        if (r_bit_cntr == 3'd7) begin
                            r_state     <= S_STOP;
                            r_stop_cntr <= 1'b0;
                            r_uart_tx   <= 1'b1;
                        end else begin
                            r_bit_cntr  <= r_bit_cntr + 3'd1;
                            // Next bit is the one about to land in r_shift[0].
                            r_uart_tx   <= r_shift[1];
                        end
                    end else begin
                        r_baud_cntr <= r_baud_cntr - BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (r_baud_cntr == BAUD_ZERO) begin
                        if (r_stop_cntr == STOP_LAST) begin
                            if (w_pop) begin
                                r_shift     <= w_pop_data;
                                r_baud_cntr <= BAUD_LAST;
                                r_uart_tx   <= 1'b0;
                                r_state     <= S_START;
                            end else begin
                                r_uart_tx   <= 1'b1;
                                r_state     <= S_IDLE;
                            end
                        end else begin
                            r_stop_cntr <= r_stop_cntr + 1'b1;
                            r_baud_cntr <= BAUD_LAST;
                        end
                    end else begin
                        r_baud_cntr <= r_baud_cntr - BAUD_ONE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_tx <= 1'b1;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Trace each byte as it leaves the FIFO for the shifter.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_pop) begin
            $display("uart_tx_fifo: pop 0x%02h", w_pop_data);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int BD    = 1000000 / 100000;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       req1, req2;
    logic [7:0] data1, data2;
    logic       ready1, ready2;
    logic       busy1, busy2;
    logic [2:0] level1, level2;
    logic       tx1, tx2;

    int total;
    int bad;

    // Reference model: bytes accepted by the handshake, in line order.
    logic [7:0] exp_q[$];
    int acc_cyc[16];
    int max_level;
    int ready_low;

    uart_tx_fifo #(.MAIN_CLK(1000000), .BAUD(100000), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_tx_req(req1), .o_tx_ready(ready1),
        .i_tx_data(data1), .o_tx_busy(busy1), .o_tx_fifo_level(level1), .o_uart_tx(tx1)
    );

    uart_tx_fifo #(.MAIN_CLK(1000000), .BAUD(100000), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
        .i_clk(clk), .i_reset(reset), .i_tx_req(req2), .o_tx_ready(ready2),
        .i_tx_data(data2), .o_tx_busy(busy2), .o_tx_fifo_level(level2), .o_uart_tx(tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Checks the line against the ideal waveform of the next nframes bytes in
    // exp_q: one start slot, 8 data slots LSB first, sb stop slots, BD cycles
    // each. The first start must appear within first_lim negedges, every later
    // one within gap_lim negedges of the previous frame's end.
    task automatic line_check(input bit sel, input int nframes, input int sb,
                              input int first_lim, input int gap_lim, input string tag);
        logic [7:0]    b;
        logic [BD-1:0] got;
        logic [BD-1:0] want;
        bit            found;
        int            lim;
        for (int f = 0; f < nframes; f++) begin
            lim   = (f == 0) ? first_lim : gap_lim;
            found = 1'b0;
            for (int w = 0; w < lim && !found; w++) begin
                @(negedge clk);
                if ((sel ? tx2 : tx1) == 1'b0) found = 1'b1;
            end
            total++;
            if (found !== 1'b1) begin
                bad++;
                $display("FAIL %s frame%0d start: no start bit within %0d cycles", tag, f, lim);
                return;
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s frame%0d: frame seen, model expects none", tag, f);
                return;
            end
            b = exp_q.pop_front();
            for (int s = 0; s < 9 + sb; s++) begin
                if (s == 0)      want = {BD{1'b0}};
                else if (s <= 8) want = {BD{b[s-1]}};
                else             want = {BD{1'b1}};
                for (int k = 0; k < BD; k++) begin
                    if (!(s == 0 && k == 0)) @(negedge clk);
                    got[k] = sel ? tx2 : tx1;
                end
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s frame%0d slot%0d: line=%b required=%b (byte 0x%02h)",
                             tag, f, s, got, want, b);
                end
            end
        end
    endtask

    // Offers src bytes to DUT1 holding each until accepted; gap_max>0 adds
    // random idle request cycles. Cycle 0 is the cycle after the next posedge.
    task automatic drive1(input logic [7:0] src[$], input int gap_max, input string tag);
        int idx;
        int cyc;
        idx = 0; cyc = 0; max_level = 0; ready_low = 0;
        @(posedge clk); #1;
        while (idx < src.size() && cyc < 3000) begin
            req1  = (gap_max == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            data1 = src[idx];
            @(negedge clk);
            if (int'(level1) > max_level) max_level = int'(level1);
            if (ready1 !== 1'b1) ready_low++;
            if (req1 && ready1) begin
                exp_q.push_back(src[idx]);
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req1 = 1'b0;
        total++;
        if (idx != src.size()) begin
            bad++;
            $display("FAIL %s drive: accepted=%0d required=%0d", tag, idx, src.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req1 = 1'b0; req2 = 1'b0; data1 = 8'h00; data2 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (tx1 !== 1'b1)    begin bad++; $display("FAIL rst uart_tx: got %b want 1", tx1); end
        total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL rst tx_ready: got %b want 0", ready1); end
        total++; if (busy1 !== 1'b0)  begin bad++; $display("FAIL rst tx_busy: got %b want 0", busy1); end
        total++; if (level1 !== 3'd0) begin bad++; $display("FAIL rst level: got %0d want 0", level1); end
        total++; if (tx2 !== 1'b1)    begin bad++; $display("FAIL rst uart_tx2: got %b want 1", tx2); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        total++; if (tx1 !== 1'b1)    begin bad++; $display("FAIL rst_drop uart_tx: got %b want 1", tx1); end
        total++; if (busy1 !== 1'b0)  begin bad++; $display("FAIL rst_drop tx_busy: got %b want 0", busy1); end
        total++; if (level1 !== 3'd0) begin bad++; $display("FAIL rst_drop level: got %0d want 0", level1); end
        @(negedge clk);
        total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL rst_after tx_ready: got %b want 1", ready1); end
    endtask

    task automatic test_single();
        logic [7:0] q[$];
        q = {8'h55};
        @(negedge clk);
        fork
            drive1(q, 0, "single");
            line_check(1'b0, 1, 1, 3, 1, "single");
            begin
                for (int k = 0; k <= 102; k++) begin
                    @(negedge clk);
                    if (k == 1) begin
                        total++; if (tx1 !== 1'b1)    begin bad++; $display("FAIL single c1 uart_tx: got %b want 1", tx1); end
                        total++; if (level1 !== 3'd1) begin bad++; $display("FAIL single c1 level: got %0d want 1", level1); end
                    end
                    if (k == 2) begin
                        total++; if (tx1 !== 1'b0)    begin bad++; $display("FAIL single latency uart_tx: got %b want 0", tx1); end
                        total++; if (level1 !== 3'd0) begin bad++; $display("FAIL single c2 level: got %0d want 0", level1); end
                    end
                    if (k == 1 + 10 * BD) begin
                        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL single last-stop busy: got %b want 1", busy1); end
                    end
                    if (k == 2 + 10 * BD) begin
                        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL single end busy: got %b want 0", busy1); end
                        total++; if (tx1 !== 1'b1)   begin bad++; $display("FAIL single end uart_tx: got %b want 1", tx1); end
                    end
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [2:0] want;
        q = {8'hA3, 8'h0F};
        @(negedge clk);
        fork
            drive1(q, 0, "b2b");
            line_check(1'b0, 2, 1, 3, 1, "b2b");
            begin
                for (int k = 0; k <= 2 + 10 * BD; k++) begin
                    @(negedge clk);
                    if (k == 1 || k == 2 || k == 1 + 10 * BD || k == 2 + 10 * BD) begin
                        want = (k == 2 + 10 * BD) ? 3'd0 : 3'd1;
                        total++;
                        if (level1 !== want) begin
                            bad++;
                            $display("FAIL b2b level cycle%0d: got %0d want %0d", k, level1, want);
                        end
                    end
                end
            end
        join
        @(negedge clk);
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b end busy: got %b want 0", busy1); end
    endtask

    task automatic test_full();
        logic [7:0] q[$];
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        @(negedge clk);
        fork
            drive1(q, 0, "full");
            line_check(1'b0, 6, 1, 3, 1, "full");
        join
        // 0x01 pops on cycle 1, 0x02..0x05 fill the FIFO by cycle 4, so ready
        // is low from cycle 5 until the pop at the end of the first frame.
        total++; if (max_level != DEPTH) begin bad++; $display("FAIL full max level: got %0d want %0d", max_level, DEPTH); end
        total++; if (acc_cyc[5] != 2 + 10 * BD) begin bad++; $display("FAIL full 0x06 accept cycle: got %0d want %0d", acc_cyc[5], 2 + 10 * BD); end
        total++; if (ready_low != 2 + 10 * BD - 5) begin bad++; $display("FAIL full ready-low cycles: got %0d want %0d", ready_low, 2 + 10 * BD - 5); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] q[$];
        int lows;
        q = {8'hFF, 8'($urandom), 8'($urandom)};
        @(negedge clk);
        drive1(q, 0, "midrst");
        // Frame starts on cycle 2; data bit 3 occupies cycles 42..51.
        for (int k = 3; k <= 44; k++) @(negedge clk);
        total++; if (level1 !== 3'd2) begin bad++; $display("FAIL midrst queued level: got %0d want 2", level1); end
        total++; if (busy1 !== 1'b1)  begin bad++; $display("FAIL midrst in-frame busy: got %b want 1", busy1); end
        @(posedge clk); #1; reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        total++; if (tx1 !== 1'b1)    begin bad++; $display("FAIL midrst uart_tx: got %b want 1", tx1); end
        total++; if (level1 !== 3'd0) begin bad++; $display("FAIL midrst level: got %0d want 0", level1); end
        total++; if (busy1 !== 1'b0)  begin bad++; $display("FAIL midrst busy: got %b want 0", busy1); end
        total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL midrst ready: got %b want 0", ready1); end
        @(posedge clk); #1; reset = 1'b0;
        lows = 0;
        for (int k = 0; k < 15 * BD; k++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL midrst silence: active cycles=%0d want 0", lows); end
        q = {8'h80};
        fork
            drive1(q, 0, "midrst_new");
            line_check(1'b0, 1, 1, 3, 1, "midrst_new");
        join
    endtask

    task automatic test_stop2();
        @(negedge clk);
        @(posedge clk); #1; req2 = 1'b1; data2 = 8'h00;
        @(negedge clk);
        total++; if (ready2 !== 1'b1) begin bad++; $display("FAIL stop2 ready: got %b want 1", ready2); end
        exp_q.push_back(8'h00);
        @(posedge clk); #1; req2 = 1'b0;
        line_check(1'b1, 1, 2, 2, 1, "stop2");
        @(negedge clk);
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL stop2 end busy: got %b want 0", busy2); end
        total++; if (tx2 !== 1'b1)   begin bad++; $display("FAIL stop2 end uart_tx: got %b want 1", tx2); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h10 + i));
        @(negedge clk);
        fork
            drive1(q, 1, "wrap");
            line_check(1'b0, 12, 1, 200, 200, "wrap");
        join
        total++; if (max_level > DEPTH) begin bad++; $display("FAIL wrap max level: got %0d limit %0d", max_level, DEPTH); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap leftover bytes: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid_frame();
        test_stop2();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
